universal_register: RTL and testbench

Parametrised N-bit universal register: the successor to the plain load/hold register in the lab datapaths. Adds per-cycle operation select (hold, parallel load, logical shift left/right with serial inputs, rotate, increment, decrement) plus carry/borrow-out and zero flags. It sits wherever a lab datapath needs a counter, shifter or accumulator-style state element, replacing ad-hoc counters and shift registers.

---
 rtl/ureg_pkg.sv | 15 +
 rtl/universal_register_next.sv | 66 ++++++
 rtl/universal_register.sv | 55 +++++
 tb/tb_universal_register.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ureg_pkg.sv
// Shared operation encodings for universal_register and its next-state logic.
package ureg_pkg;
  localparam int UREG_OP_W = 3;

  typedef enum logic [UREG_OP_W-1:0] {
    UREG_HOLD = 3'd0,
    UREG_LOAD = 3'd1,
    UREG_SHL  = 3'd2,
    UREG_SHR  = 3'd3,
    UREG_ROL  = 3'd4,
    UREG_ROR  = 3'd5,
    UREG_INC  = 3'd6,
    UREG_DEC  = 3'd7
  } ureg_op_e;
endpackage

// File: rtl/universal_register_next.sv
// Combinational next-state logic for universal_register: computes the next Q
// and the next carry/borrow/shift-out flag from the current state and the OP.
module universal_register_next
  import ureg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_q,
  input  logic                 i_co,
  input  logic [N-1:0]         i_d,
  input  logic [UREG_OP_W-1:0] i_op,
  input  logic                 i_sil,
  input  logic                 i_sir,
  output logic [N-1:0]         o_q_nxt,
  output logic                 o_co_nxt
);
  logic [N:0] w_inc;
  logic [N:0] w_dec;

  // One extra bit on the arithmetic paths carries the wrap flag out.
  assign w_inc = {1'b0, i_q} + {{N{1'b0}}, 1'b1};
  assign w_dec = {1'b0, i_q} - {{N{1'b0}}, 1'b1};

  always_comb begin
    o_q_nxt  = i_q;
    o_co_nxt = i_co;
    case (i_op)
      UREG_HOLD: begin
        o_q_nxt  = i_q;
        o_co_nxt = i_co;
      end
      UREG_LOAD: begin
        o_q_nxt  = i_d;
        o_co_nxt = 1'b0;
      end
      UREG_SHL: begin
        o_q_nxt  = {i_q[N-2:0], i_sil};
        o_co_nxt = i_q[N-1];
      end
      UREG_SHR: begin
        o_q_nxt  = {i_sir, i_q[N-1:1]};
        o_co_nxt = i_q[0];
      end
      UREG_ROL: begin
        o_q_nxt  = {i_q[N-2:0], i_q[N-1]};
        o_co_nxt = i_q[N-1];
      end
      UREG_ROR: begin
        o_q_nxt  = {i_q[0], i_q[N-1:1]};
        o_co_nxt = i_q[0];
      end
      UREG_INC: begin
        o_q_nxt  = w_inc[N-1:0];
        o_co_nxt = w_inc[N];
      end
      UREG_DEC: begin
        o_q_nxt  = w_dec[N-1:0];
        o_co_nxt = w_dec[N];
      end
      default: begin
        o_q_nxt  = i_q;
        o_co_nxt = i_co;
      end
    endcase
  end
endmodule

// File: rtl/universal_register.sv
// N-bit universal register: Q/CO state flops with synchronous reset, zero flag,
// and an optional parity output enabled by defining UREG_PARITY_EN.
module universal_register
  import ureg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 R,
  input  logic [N-1:0]         D,
  input  logic [UREG_OP_W-1:0] OP,
  input  logic                 SIL,
  input  logic                 SIR,
  output logic [N-1:0]         Q,
  output logic                 CO,
  output logic                 Z
`ifdef UREG_PARITY_EN
  ,
  output logic                 P
`endif
);
  logic [N-1:0] r_q;
  logic         r_co;
  logic [N-1:0] w_q_nxt;
  logic         w_co_nxt;

  universal_register_next #(.N(N)) u_next (
    .i_q      (r_q),
    .i_co     (r_co),
    .i_d      (D),
    .i_op     (OP),
    .i_sil    (SIL),
    .i_sir    (SIR),
    .o_q_nxt  (w_q_nxt),
    .o_co_nxt (w_co_nxt)
  );

  // Reset overrides whatever OP is presented on the same edge.
  always_ff @(posedge clock) begin
    if (R) begin
      r_q  <= '0;
      r_co <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_co <= w_co_nxt;
    end
  end

  assign Q  = r_q;
  assign CO = r_co;
  assign Z  = (r_q == '0);
`ifdef UREG_PARITY_EN
  assign P  = ^r_q;
`endif
endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register: directed vector table, a
// between-edges reset pulse, then randomized ops against an arithmetic model.
module tb_universal_register;
  import ureg_pkg::*;
  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clock = 1'b0;
  logic         R = 1'b0;
  logic [N-1:0] D = '0;
  logic [2:0]   OP = 3'd0;
  logic         SIL = 1'b0;
  logic         SIR = 1'b0;
  logic [N-1:0] Q;
  logic         CO;
  logic         Z;
`ifdef UREG_PARITY_EN
  logic         P;
`endif

  universal_register #(.N(N)) dut (
    .clock (clock),
    .R     (R),
    .D     (D),
    .OP    (OP),
    .SIL   (SIL),
    .SIR   (SIR),
    .Q     (Q),
    .CO    (CO),
    .Z     (Z)
`ifdef UREG_PARITY_EN
    ,
    .P     (P)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int m_q    = 0;
  int m_co   = 0;

  typedef struct {
    logic       r;
    logic [2:0] op;
    logic [3:0] d;
    logic       sil;
    logic       sir;
    logic [3:0] exp_q;
    logic       exp_co;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the register value.
  task automatic model(input int r, input int op, input int d, input int sil, input int sir);
    int msb, lsb;
    msb = (m_q >> (N - 1)) & 1;
    lsb = m_q & 1;
    if (r != 0) begin
      m_q = 0; m_co = 0;
    end else begin
      case (op)
        1: begin m_q = d; m_co = 0; end
        2: begin m_co = msb; m_q = ((m_q * 2) + sil) & MASK; end
        3: begin m_co = lsb; m_q = (m_q / 2) + sir * (1 << (N - 1)); end
        4: begin m_co = msb; m_q = ((m_q * 2) + msb) & MASK; end
        5: begin m_co = lsb; m_q = (m_q / 2) + lsb * (1 << (N - 1)); end
        6: begin m_co = (m_q == MASK) ? 1 : 0; m_q = (m_q + 1) & MASK; end
        7: begin m_co = (m_q == 0) ? 1 : 0; m_q = (m_q + MASK) & MASK; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [2:0] op, input logic [3:0] d,
                      input logic sil, input logic sir);
    R = r; OP = op; D = d; SIL = sil; SIR = sir;
    model(int'(r), int'(op), int'(d), int'(sil), int'(sir));
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string name, input int eq, input int eco);
    chk({name, ".Q"}, int'(Q), eq);
    chk({name, ".CO"}, int'(CO), eco);
    chk({name, ".Z"}, int'(Z), (eq == 0) ? 1 : 0);
`ifdef UREG_PARITY_EN
    chk({name, ".P"}, int'(P), $countones(eq[N-1:0]) % 2);
`endif
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd6, 4'hF, 1'b1, 1'b1, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 4'b1101, 1'b0, 1'b0, 4'b1101, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 4'h0, 1'b1, 1'b0, 4'b1011, 1'b1};
    vecs[3]  = '{1'b1, 3'd6, 4'hA, 1'b1, 1'b1, 4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 4'b1001, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 4'h6, 1'b1, 1'b1, 4'b1001, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 4'h3, 1'b0, 1'b1, 4'b1001, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 4'hC, 1'b1, 1'b0, 4'b1001, 1'b0};
    vecs[8]  = '{1'b0, 3'd1, 4'b1110, 1'b0, 1'b0, 4'b1110, 1'b0};
    vecs[9]  = '{1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[10] = '{1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[11] = '{1'b0, 3'd7, 4'h0, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[12] = '{1'b0, 3'd1, 4'b1001, 1'b0, 1'b0, 4'b1001, 1'b0};
    vecs[13] = '{1'b0, 3'd2, 4'h0, 1'b0, 1'b0, 4'b0010, 1'b1};
    vecs[14] = '{1'b0, 3'd3, 4'h0, 1'b0, 1'b1, 4'b1001, 1'b0};
    vecs[15] = '{1'b0, 3'd1, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[16] = '{1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 4'b0001, 1'b1};
    vecs[17] = '{1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[18] = '{1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[19] = '{1'b0, 3'd4, 4'h0, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[20] = '{1'b0, 3'd1, 4'b0101, 1'b0, 1'b0, 4'b0101, 1'b0};
    vecs[21] = '{1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[22] = '{1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[23] = '{1'b0, 3'd5, 4'h0, 1'b0, 1'b0, 4'b1000, 1'b1};
    vecs[24] = '{1'b0, 3'd7, 4'h0, 1'b0, 1'b0, 4'b0111, 1'b0};

    @(posedge clock);
    #1;
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].r, vecs[i].op, vecs[i].d, vecs[i].sil, vecs[i].sir);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_q), int'(vecs[i].exp_co));
    end

    // Reset pulse that starts and ends between edges must not clear Q.
    R = 1'b0; OP = 3'd0;
    #1 R = 1'b1;
    #2 R = 1'b0;
    @(posedge clock);
    #1;
    chk_all("mid_edge_reset", 7, 0);

    // Random ops, with occasional reset, against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), 3'($urandom_range(7)), 4'($urandom),
           1'($urandom), 1'($urandom));
      chk_all($sformatf("rnd%0d", i), m_q, m_co);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
